// File: rtl/ascon_block_packer_if.sv
// Byte-stream in / 64-bit rate-block out handshake bundle for the ASCON packer.
interface ascon_block_packer_if;
  logic        start_i;
  logic [7:0]  byte_i;
  logic        byte_valid_i;
  logic        byte_last_i;
  logic        byte_empty_i;
  logic        byte_ready_o;
  logic [63:0] block_o;
  logic        block_type_o;
  logic        block_last_o;
  logic [3:0]  block_bytes_o;
  logic        block_valid_o;
  logic        block_ready_i;
  logic        busy_o;
  logic        done_o;

  // Packer side
  modport slave (
    input  start_i, byte_i, byte_valid_i, byte_last_i, byte_empty_i, block_ready_i,
    output byte_ready_o, block_o, block_type_o, block_last_o, block_bytes_o,
           block_valid_o, busy_o, done_o
  );

  // Byte source / ASCON core side
  modport master (
    output start_i, byte_i, byte_valid_i, byte_last_i, byte_empty_i, block_ready_i,
    input  byte_ready_o, block_o, block_type_o, block_last_o, block_bytes_o,
           block_valid_o, busy_o, done_o
  );
endinterface

// File: rtl/ascon_block_packer.sv
// Packs AD then PT byte streams into padded 64-bit ASCON-128 rate blocks.
// Byte k of a block lives in bits 63-8k downto 56-8k.
module ascon_block_packer (
  input  logic               clock_i,
  input  logic               reset_i,
  ascon_block_packer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_AD_FILL, S_PT_FILL, S_OUT} state_t;

  localparam logic [63:0] PAD_BLOCK = 64'h8000_0000_0000_0000;

  state_t      state_q, state_d;
  logic [63:0] buf_q, buf_d;
  logic [3:0]  k_q, k_d;
  logic [3:0]  bytes_q, bytes_d;
  logic        pad_q, pad_d;
  logic        type_q, type_d;
  logic        last_q, last_d;
  logic        done_q, done_d;
  logic        ready_q, ready_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic [3:0]  k_inc;
  logic [63:0] buf_wr;

  // Write byte v into slot pos of the block.
  function automatic logic [63:0] put_byte(input logic [63:0] b, input logic [3:0] pos,
                                           input logic [7:0] v);
    logic [63:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (pos == 4'(i)) r[63-8*i -: 8] = v;
    end
    return r;
  endfunction

  // Place the 0x80 pad byte at slot pos and zero every slot after it.
  // pos == 8 leaves a full block untouched.
  function automatic logic [63:0] pad_from(input logic [63:0] b, input logic [3:0] pos);
    logic [63:0] r;
    r = b;
    for (int i = 0; i < 8; i++) begin
      if (pos == 4'(i))     r[63-8*i -: 8] = 8'h80;
      else if (4'(i) > pos) r[63-8*i -: 8] = 8'h00;
    end
    return r;
  endfunction

  // Next-state, buffer and block-field computation.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    k_d     = k_q;
    bytes_d = bytes_q;
    pad_d   = pad_q;
    type_d  = type_q;
    last_d  = last_q;
    done_d  = 1'b0;
    k_inc   = k_q + 4'd1;
    buf_wr  = put_byte(buf_q, k_q, bus.byte_i);

    case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          state_d = S_AD_FILL;
          buf_d   = '0;
          k_d     = '0;
          bytes_d = '0;
          pad_d   = 1'b0;
          type_d  = 1'b0;
          last_d  = 1'b0;
        end
      end
      S_AD_FILL, S_PT_FILL: begin
        if (bus.byte_valid_i) begin
          if (bus.byte_last_i && bus.byte_empty_i) begin
            if (state_q == S_AD_FILL && k_q == 4'd0) begin
              // Empty AD produces no block at all.
              state_d = S_PT_FILL;
              type_d  = 1'b1;
              buf_d   = '0;
              k_d     = '0;
            end else begin
              buf_d   = pad_from(buf_q, k_q);
              last_d  = 1'b1;
              bytes_d = k_q;
              state_d = S_OUT;
            end
          end else if (k_inc == 4'd8) begin
            // A last byte filling the block defers its pad to an extra block.
            buf_d   = buf_wr;
            last_d  = 1'b0;
            bytes_d = 4'd8;
            pad_d   = bus.byte_last_i;
            state_d = S_OUT;
          end else if (bus.byte_last_i) begin
            buf_d   = pad_from(buf_wr, k_inc);
            last_d  = 1'b1;
            bytes_d = k_inc;
            state_d = S_OUT;
          end else begin
            buf_d = buf_wr;
            k_d   = k_inc;
          end
        end
      end
      S_OUT: begin
        if (bus.block_ready_i) begin
          if (pad_q) begin
            buf_d   = PAD_BLOCK;
            bytes_d = 4'd0;
            last_d  = 1'b1;
            pad_d   = 1'b0;
          end else if (last_q && !type_q) begin
            state_d = S_PT_FILL;
            type_d  = 1'b1;
            k_d     = '0;
            buf_d   = '0;
          end else if (last_q) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = type_q ? S_PT_FILL : S_AD_FILL;
            k_d     = '0;
            buf_d   = '0;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    ready_d = (state_d == S_AD_FILL) || (state_d == S_PT_FILL);
    valid_d = (state_d == S_OUT);
    busy_d  = (state_d != S_IDLE);
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      buf_q   <= '0;
      k_q     <= '0;
      bytes_q <= '0;
      pad_q   <= 1'b0;
      type_q  <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      k_q     <= k_d;
      bytes_q <= bytes_d;
      pad_q   <= pad_d;
      type_q  <= type_d;
      last_q  <= last_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.byte_ready_o  = ready_q;
  assign bus.block_o       = buf_q;
  assign bus.block_type_o  = type_q;
  assign bus.block_last_o  = last_q;
  assign bus.block_bytes_o = bytes_q;
  assign bus.block_valid_o = valid_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;

endmodule

// File: tb/tb_ascon_block_packer.sv
// Testbench for ascon_block_packer: directed scenarios plus random sessions
// checked against a padding-rule reference model.
module tb_ascon_block_packer;

  typedef logic [7:0] bq_t[$];
  typedef struct packed {
    logic [63:0] data;
    logic        t;
    logic        l;
    logic [3:0]  n;
  } blk_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ascon_block_packer_if bus();
  ascon_block_packer dut (.clock_i(clk), .reset_i(rst), .bus(bus));

  blk_t got_q[$];
  blk_t exp_q[$];
  int   got_base = 0;
  int   chk_cnt = 0, pass_cnt = 0;
  int   done_cnt = 0, done_cyc = 0, done_len_bad = 0;
  int   bad_ready = 0, bad_stable = 0, stall_cnt = 0;
  int   cyc = 0, start_cyc = 0;
  int   br_mode = 0;
  bit   noise = 0, gaps = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    chk_cnt++;
    assert (obs === exp) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Block-side monitor: collects transfers and watches handshake invariants.
  initial begin : monitor
    blk_t cur, pb;
    logic pv, pdone;
    pv = 1'b0; pdone = 1'b0; pb = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 1'b0; pdone = 1'b0;
      end else begin
        cur = {bus.block_o, bus.block_type_o, bus.block_last_o, bus.block_bytes_o};
        if (bus.block_valid_o && bus.byte_ready_o) bad_ready++;
        if (pv && (!bus.block_valid_o || cur !== pb)) bad_stable++;
        if (bus.block_valid_o && !bus.block_ready_i) stall_cnt++;
        if (bus.block_valid_o && bus.block_ready_i) got_q.push_back(cur);
        pv = bus.block_valid_o && !bus.block_ready_i;
        pb = cur;
        if (bus.done_o) begin
          done_cnt++;
          done_cyc = cyc;
          if (pdone) done_len_bad++;
        end
        pdone = bus.done_o;
      end
    end
  end

  // Downstream ready: always 1, random, or a 20-cycle stall on the first PT block.
  initial begin : rdy
    bit held;
    held = 0;
    bus.block_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (br_mode == 2 && !held && bus.block_valid_o && bus.block_type_o) begin
        bus.block_ready_i = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        bus.block_ready_i = 1'b1;
        held = 1;
      end else begin
        if (br_mode != 2) held = 0;
        bus.block_ready_i = (br_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // Reference model: full 8-byte blocks, then a final block holding the
  // remainder followed by 0x80; an empty AD stream contributes nothing.
  task automatic model(input bq_t d, input bit pt);
    blk_t b;
    int n, nf, r;
    n = d.size();
    if (!pt && n == 0) return;
    nf = n / 8;
    r  = n % 8;
    for (int i = 0; i < nf; i++) begin
      b.data = '0;
      for (int j = 0; j < 8; j++) b.data[63-8*j -: 8] = d[8*i+j];
      b.t = pt; b.l = 1'b0; b.n = 4'd8;
      exp_q.push_back(b);
    end
    b.data = '0;
    for (int j = 0; j < r; j++) b.data[63-8*j -: 8] = d[8*nf+j];
    b.data[63-8*r -: 8] = 8'h80;
    b.t = pt; b.l = 1'b1; b.n = 4'(r);
    exp_q.push_back(b);
  endtask

  task automatic beat(input logic [7:0] b, input bit last, input bit empty);
    bit acc;
    int n, g;
    if (gaps) begin
      g = $urandom_range(0, 2);
      repeat (g) begin @(posedge clk); #1; end
    end
    bus.byte_i = b; bus.byte_last_i = last; bus.byte_empty_i = empty;
    bus.byte_valid_i = 1'b1;
    acc = 0; n = 0;
    while (!acc && n < 200) begin
      bus.start_i = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      acc = bus.byte_ready_o;
      @(posedge clk); #1;
      n++;
    end
    bus.byte_valid_i = 1'b0; bus.start_i = 1'b0;
    bus.byte_last_i = 1'b0; bus.byte_empty_i = 1'b0;
    chk("beat_accepted", 64'(acc), 64'd1);
  endtask

  task automatic send(input bq_t d, input bit empty_term);
    if (d.size() == 0) beat(8'h00, 1'b1, 1'b1);
    else begin
      for (int i = 0; i < d.size(); i++) beat(d[i], (i == d.size() - 1) && !empty_term, 1'b0);
      if (empty_term) beat(8'h00, 1'b1, 1'b1);
    end
  endtask

  task automatic session(input bq_t ad, input bq_t pt, input bit ad_e, input bit pt_e);
    int d0, n;
    d0 = done_cnt;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    start_cyc = cyc;
    chk("ready_after_start", 64'(bus.byte_ready_o), 64'd1);
    send(ad, ad_e);
    send(pt, pt_e);
    n = 0;
    while (done_cnt == d0 && n < 300) begin @(posedge clk); #1; n++; end
    chk("busy_after_done", 64'(bus.busy_o), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_pulses", 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic compare(input string tag);
    chk({tag, "_nblocks"}, 64'(got_q.size() - got_base), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (got_base + i < got_q.size()) begin
        chk({tag, "_data"}, got_q[got_base+i].data, exp_q[i].data);
        chk({tag, "_type_last_bytes"},
            64'({got_q[got_base+i].t, got_q[got_base+i].l, got_q[got_base+i].n}),
            64'({exp_q[i].t, exp_q[i].l, exp_q[i].n}));
      end
    end
    got_base = got_q.size();
    exp_q.delete();
  endtask

  task automatic push_s1();
    exp_q.push_back({64'h3230323380000000, 1'b0, 1'b1, 4'd4});
    exp_q.push_back({64'h436F6E636576657A, 1'b1, 1'b0, 4'd8});
    exp_q.push_back({64'h204153434F4E2065, 1'b1, 1'b0, 4'd8});
    exp_q.push_back({64'h6E2053797374656D, 1'b1, 1'b0, 4'd8});
    exp_q.push_back({64'h566572696C6F6780, 1'b1, 1'b1, 4'd7});
  endtask

  initial begin : main
    bq_t s1_ad, s1_pt, none, ad8, ad16, ad, pt;
    int s0, d0, la, lp;
    bit ae, pe;

    rst = 1'b1;
    bus.start_i = 1'b0; bus.byte_i = 8'h00; bus.byte_valid_i = 1'b0;
    bus.byte_last_i = 1'b0; bus.byte_empty_i = 1'b0;
    #7;
    chk("rst_ready", 64'(bus.byte_ready_o), 64'd0);
    chk("rst_valid", 64'(bus.block_valid_o), 64'd0);
    chk("rst_block", bus.block_o, 64'd0);
    chk("rst_fields", 64'({bus.block_type_o, bus.block_last_o, bus.block_bytes_o}), 64'd0);
    chk("rst_busy_done", 64'({bus.busy_o, bus.done_o}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    s1_ad = str2q("2023");
    s1_pt = str2q("Concevez ASCON en SystemVerilog");
    for (int i = 0; i < 8; i++) ad8.push_back(8'(i));
    for (int i = 0; i < 16; i++) ad16.push_back(8'(8'h10 + i));

    // Scenario 1: reference vectors
    br_mode = 0;
    session(s1_ad, s1_pt, 1'b0, 1'b0);
    push_s1();
    compare("s1");

    // AD of exactly 8 bytes: full block then a separate pad block
    session(ad8, none, 1'b0, 1'b0);
    exp_q.push_back({64'h0001020304050607, 1'b0, 1'b0, 4'd8});
    exp_q.push_back({64'h8000000000000000, 1'b0, 1'b1, 4'd0});
    exp_q.push_back({64'h8000000000000000, 1'b1, 1'b1, 4'd0});
    compare("ad8");

    // Empty AD and empty PT: only the PT pad block
    session(none, none, 1'b0, 1'b0);
    exp_q.push_back({64'h8000000000000000, 1'b1, 1'b1, 4'd0});
    compare("empty");

    // Throughput: 16 AD bytes at one per cycle, pad block back-to-back
    session(ad16, none, 1'b0, 1'b0);
    chk("cycles_start_to_done", 64'(done_cyc - start_cyc), 64'd21);
    model(ad16, 1'b0);
    model(none, 1'b1);
    compare("thru");

    // Backpressure on the first PT block
    s0 = stall_cnt;
    br_mode = 2;
    session(s1_ad, s1_pt, 1'b0, 1'b0);
    chk("bp_stall_cycles", 64'(stall_cnt - s0), 64'd20);
    push_s1();
    compare("bp");
    br_mode = 0;
    @(posedge clk); #1;

    // Reset after three PT bytes
    d0 = done_cnt;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    send(s1_ad, 1'b0);
    for (int i = 0; i < 3; i++) beat(s1_pt[i], 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    chk("midrst_outputs",
        64'({bus.byte_ready_o, bus.block_valid_o, bus.block_type_o, bus.block_last_o,
             bus.block_bytes_o, bus.busy_o, bus.done_o}), 64'd0);
    chk("midrst_block", bus.block_o, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("midrst_idle", 64'({bus.busy_o, bus.byte_ready_o}), 64'd0);
    chk("midrst_no_done", 64'(done_cnt - d0), 64'd0);
    got_base = got_q.size();
    session(s1_ad, s1_pt, 1'b0, 1'b0);
    push_s1();
    compare("after_rst");

    // Spurious start pulses during FILL and OUT
    noise = 1; br_mode = 1;
    session(s1_ad, s1_pt, 1'b0, 1'b0);
    push_s1();
    compare("start_noise");

    // Random sessions against the model
    gaps = 1;
    for (int s = 0; s < 12; s++) begin
      ad.delete(); pt.delete();
      la = $urandom_range(0, 20);
      lp = $urandom_range(0, 20);
      for (int i = 0; i < la; i++) ad.push_back(8'($urandom));
      for (int i = 0; i < lp; i++) pt.push_back(8'($urandom));
      ae = (la % 8 != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      pe = 1'($urandom_range(0, 1));
      noise = 1'($urandom_range(0, 1));
      model(ad, 1'b0);
      model(pt, 1'b1);
      session(ad, pt, ae, pe);
      compare("rand");
    end
    noise = 0; gaps = 0; br_mode = 0;

    chk("ready_low_while_valid", 64'(bad_ready), 64'd0);
    chk("block_held_until_accepted", 64'(bad_stable), 64'd0);
    chk("done_single_cycle", 64'(done_len_bad), 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/ascon_block_packer.md
# ascon_block_packer

Upstream stage of the ASCON-128 encryption datapath. Packs a byte stream into the 64-bit rate blocks consumed by the ASCON core. A session carries associated data (AD) followed by plaintext (PT). The block applies ASCON-128 padding (0x80 then zeros), marks block type, last flag and valid byte count, and hands each block downstream over a valid/ready handshake so the core's per-block permutation latency throttles the byte source.

## Interface
Parameters: none (rate fixed at 64 bits / 8 bytes).

Ports:
- clock_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- start_i  in  1  one-cycle pulse that opens a session; honoured only in IDLE
- byte_i  in  8  data byte
- byte_valid_i  in  1  byte_i/byte_last_i/byte_empty_i valid
- byte_last_i  in  1  last beat of the current stream (AD or PT)
- byte_empty_i  in  1  with byte_last_i: beat carries no data byte
- byte_ready_o  out  1  packer accepts a beat this cycle
- block_o  out  64  packed block; first byte of the block in bits 63:56
- block_type_o  out  1  0 = AD, 1 = PT
- block_last_o  out  1  final (padded) block of its stream
- block_bytes_o  out  4  message bytes in block, 0..8 (excludes the pad byte)
- block_valid_o  out  1  block outputs valid, held until accepted
- block_ready_i  in  1  downstream accepts block
- busy_o  out  1  high when not in IDLE
- done_o  out  1  one-cycle pulse after the last PT block is accepted

## Operation
- Beat accepted when byte_valid_i && byte_ready_o; block transferred when block_valid_o && block_ready_i.
- States:
  - IDLE: ready=0, valid=0. start_i clears the buffer and the byte count k, goes to AD_FILL.
  - AD_FILL / PT_FILL: ready=1, valid=0.
  - OUT: ready=0, valid=1.
- Data beat at count k: byte written at position k (bits 63-8k downto 56-8k), then k+1.
  - Not last, k+1=8: go to OUT with last=0, bytes=8.
  - Last, k+1<8: write 0x80 at position k+1, zero the remaining bytes, go to OUT with last=1, bytes=k+1.
  - Last, k+1=8: go to OUT with last=0, bytes=8, and set pad_pending.
- Empty last beat at count k: write 0x80 at position k, zero the rest, last=1, bytes=k.
  - Exception, AD stream with k=0: no block is emitted; go directly to PT_FILL.
  - PT stream with k=0: emit 0x8000000000000000 with last=1, bytes=0.
- OUT on transfer:
  - pad_pending set: load 0x8000000000000000, bytes=0, last=1, clear pad_pending, stay in OUT.
  - Else last with AD: go to PT_FILL, k=0.
  - Else last with PT: go to IDLE and pulse done_o.
  - Else: return to the same FILL state, k=0, buffer cleared.
- block_type_o is 0 for all blocks emitted from the AD phase and 1 for all blocks from the PT phase.
- start_i outside IDLE is ignored. byte_valid_i in IDLE or OUT is not accepted (ready=0).

## Timing
- Reset (asynchronous, immediate): state IDLE, k=0, pad_pending=0, and all outputs 0: byte_ready_o, block_o, block_type_o, block_last_o, block_bytes_o, block_valid_o, busy_o, done_o.
- Reset mid-session discards the partial block and any pending pad block. No done_o is produced.
- start_i at cycle t: byte_ready_o=1 at t+1.
- Block-completing beat at cycle t: block_valid_o=1 and all block fields stable from t+1 until the transfer cycle.
- Transfer at t (no pad pending): byte_ready_o=1 at t+1. Back-to-back 8-byte blocks therefore cost 8+1 cycles minimum.
- Pad block follows its full block at t+1 if block_ready_i is held high.
- done_o is high at t+1 after the final PT transfer; busy_o falls in the same cycle.
- Throughput: one byte per cycle in the FILL states. No combinational path from byte_valid_i to byte_ready_o. block_ready_i may be combinationally observed by the state update.

## Test plan
- AD "2023" (4 bytes, last on 0x33), then PT "Concevez ASCON en SystemVerilog" (31 bytes), block_ready_i=1. Expected:
  - AD block 0x3230323380000000, type 0, last 1, bytes 4.
  - PT blocks 0x436F6E636576657A, 0x204153434F4E2065, 0x6E2053797374656D with last 0, bytes 8.
  - Final PT block 0x566572696C6F6780, last 1, bytes 7.
  - done_o pulses once.
- AD of exactly 8 bytes 0x00..0x07 with last on 0x07. Expected: block 0x0001020304050607 (last 0, bytes 8), then 0x8000000000000000 (last 1, bytes 0, type 0).
- Empty AD (first beat empty+last), then empty PT. Expected: no AD block; one PT block 0x8000000000000000 (type 1, last 1, bytes 0); then done_o.
- Backpressure: hold block_ready_i=0 for 20 cycles on the first PT block. Expected: block_valid_o and block_o are held stable, byte_ready_o=0, no bytes are lost, and the sequence is identical to scenario 1.
- Assert reset_i for one cycle after 3 PT bytes. Expected: all outputs 0 immediately, IDLE; a following start_i plus scenario 1 reproduces scenario 1 exactly.
- start_i pulsed during AD_FILL and during OUT. Expected: ignored; block stream unchanged.
